rca_pipe_addsub: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor built from segmented fa chains.
//  It is the successor of the fixed 6-bit ripple adder, with generic width and a registered carry every SEG bits.
//  It adds an add/subtract mode, signed overflow flag and valid/ready flow control.
//  It sits in the FP multiplier exponent path (biased-exponent add, bias subtract) and in mantissa post-normalise increment.

---
 rtl/rca_pkg.sv | 20 ++
 rtl/rca_seg.sv | 36 +++
 rtl/rca_pipe_addsub.sv | 139 +++++++++++++
 tb/tb_rca_pipe_addsub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rca_pkg: shared definitions for the pipelined ripple-carry adder/subtractor.
//   stages(width, seg) : number of pipeline stages, ceil(width/seg)
//   fa(a, b, ci)       : one full-adder cell, returns {carry_out, sum}
//   EXP_W, BIAS        : FP exponent width and bias used by the exponent path
package rca_pkg;

    localparam int EXP_W = 8;
    localparam int BIAS  = 127;

    // Number of SEG-bit stages needed to cover WIDTH bits (last may be narrower).
    function automatic int stages(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // Full-adder cell: {carry_out, sum}.
    function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/rca_seg.sv
// rca_seg: combinational W-bit ripple-carry chain of full-adder cells.
//   a, b      : segment operands
//   cin       : carry into bit 0
//   s         : segment sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used with cout for signed overflow)
module rca_seg
    import rca_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic carry_s;
    logic cmsb_s;

    // Ripple the carry bit by bit, remembering the carry that enters the top bit.
    always_comb begin
        carry_s = cin;
        cmsb_s  = cin;
        s       = '0;
        for (int i = 0; i < W; i++) begin
            cmsb_s             = carry_s;
            {carry_s, s[i]}    = fa(a[i], b[i], carry_s);
        end
        cout     = carry_s;
        c_msb_in = cmsb_s;
    end

endmodule

// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub: pipelined WIDTH-bit adder/subtractor, one SEG-bit ripple
// segment resolved per stage with the carry registered between stages.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, cin, sub)
//   sub                   : 0 -> s = a + b + cin, 1 -> s = a - b (cin ignored)
//   out_valid / out_ready : result handshake (s, cout, ovf)
//   cout                  : carry out of MSB (subtract: 1 means no borrow)
//   ovf                   : two's-complement overflow
// Latency STAGES cycles, throughput one beat per cycle, results in order.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG);

    logic             advance_s;
    logic [WIDTH-1:0] bx_s;
    logic             c0_s;
    logic             ovf_d;
    logic             ovf_q;

    // One global advance: the whole pipe moves unless a result is stuck at the output.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Subtraction as a + ~b + 1.
    assign bx_s = sub ? ~b : b;
    assign c0_s = sub ? 1'b1 : cin;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            localparam int LO = k * SEG;
            localparam int HI = ((k + 1) * SEG > WIDTH) ? (WIDTH - 1) : ((k + 1) * SEG - 1);
            localparam int SW = HI - LO + 1;

            // Operand bits not yet consumed (skewed), carry/valid in, and sum so far.
            logic [WIDTH-1:LO] a_src_s;
            logic [WIDTH-1:LO] b_src_s;
            logic              cin_s;
            logic              v_d;
            logic              c_d;
            logic              c_msb_s;
            logic [SW-1:0]     seg_sum_s;
            logic [HI:0]       sum_d;
            logic [HI:0]       sum_q;
            logic              c_q;
            logic              v_q;

            if (k == 0) begin : g_head
                assign a_src_s = a;
                assign b_src_s = bx_s;
                assign cin_s   = c0_s;
                assign v_d     = in_valid;
                assign sum_d   = seg_sum_s;
            end else begin : g_body
                assign a_src_s = g_stg[k-1].g_skew.a_q;
                assign b_src_s = g_stg[k-1].g_skew.b_q;
                assign cin_s   = g_stg[k-1].c_q;
                assign v_d     = g_stg[k-1].v_q;
                // Lower sum segments ride along (deskew) so the beat exits whole.
                assign sum_d   = {seg_sum_s, g_stg[k-1].sum_q};
            end

            rca_seg #(.W(SW)) u_seg (
                .a        (a_src_s[HI:LO]),
                .b        (b_src_s[HI:LO]),
                .cin      (cin_s),
                .s        (seg_sum_s),
                .cout     (c_d),
                .c_msb_in (c_msb_s)
            );

            // Stage register: partial sum, segment carry and valid; hold on stall.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                end else if (advance_s) begin
                    sum_q <= sum_d;
                    c_q   <= c_d;
                    v_q   <= v_d;
                end
            end

            if (k < STAGES - 1) begin : g_skew
                logic [WIDTH-1:HI+1] a_q;
                logic [WIDTH-1:HI+1] b_q;

                // Skew register: carry the upper operand segments to the next stage.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance_s) begin
                        a_q <= a_src_s[WIDTH-1:HI+1];
                        b_q <= b_src_s[WIDTH-1:HI+1];
                    end
                end
            end
        end
    endgenerate

    // Overflow comes from the final segment's MSB carry-in versus carry-out.
    assign ovf_d = g_stg[STAGES-1].c_d ^ g_stg[STAGES-1].c_msb_s;

    // Overflow flag register, aligned with the final stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance_s) begin
            ovf_q <= ovf_d;
        end
    end

    assign s         = g_stg[STAGES-1].sum_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign out_valid = g_stg[STAGES-1].v_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb_rca_pipe_addsub: drives an 8-bit (4+4) and a 6-bit (4+2) instance,
// scoreboarding every emitted beat against an integer-arithmetic model.
module tb_rca_pipe_addsub;

    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       v8, r8, c8, sb8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, s8;
    logic       v6, r6, c6, sb6, ov6, or6, co6, of6;
    logic [5:0] a6, b6, s6;

    rca_pipe_addsub #(.WIDTH(8), .SEG(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .cin(c8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(of8)
    );

    rca_pipe_addsub #(.WIDTH(6), .SEG(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .a(a6), .b(b6),
        .cin(c6), .sub(sb6), .out_valid(ov6), .out_ready(or6), .s(s6), .cout(co6), .ovf(of6)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int cyc;
        int stl;
    } ent_t;

    ent_t q8[$];
    ent_t q6[$];
    int   em8_res[$];
    int   em8_cyc[$];
    int   cyc = 0;
    int   stl8 = 0;
    int   stl6 = 0;
    int   acc6 = 0;
    int   checks = 0;
    int   failures = 0;

    int ta[4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    int tb[4] = '{8'h01, 8'h01, 8'h07, 8'h01};
    int ts[4] = '{0, 0, 1, 1};
    int te[4] = '{32'h100, 32'h280, 32'h0FE, 32'h37F};
    int ba[4] = '{1, 3, 10, 8'hFF};
    int bb[4] = '{2, 4, 20, 8'hFF};
    int be[4] = '{32'h003, 32'h007, 32'h01E, 32'h1FE};

    // Reference: {ovf, cout, s} from plain integer arithmetic on a w-bit word.
    function automatic int ref_res(input int w, input int a, input int b, input int cin, input int sub);
        int m, half, u, sa, sb, ex, cy, ov;
        m    = 1 << w;
        half = m / 2;
        u    = sub ? (a + (m - b)) : (a + b + cin);
        cy   = (u >= m) ? 1 : 0;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        ex   = sub ? (sa - sb) : (sa + sb + cin);
        ov   = (ex < -half || ex >= half) ? 1 : 0;
        return (ov << (w + 1)) | (cy << w) | (u % m);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set8(input logic iv, input int a, input int b, input int c, input int sb, input logic ordy);
        v8 = iv; a8 = a[7:0]; b8 = b[7:0]; c8 = c[0]; sb8 = sb[0]; or8 = ordy;
    endtask

    task automatic set6(input logic iv, input int a, input int b, input int c, input int sb, input logic ordy);
        v6 = iv; a6 = a[5:0]; b6 = b[5:0]; c6 = c[0]; sb6 = sb[0]; or6 = ordy;
    endtask

    // One clock cycle: score handshakes on both instances, then step to edge+1.
    task automatic tick();
        ent_t e;
        #1;
        check_eq("rdy8", {31'b0, r8}, {31'b0, (!ov8 || or8)});
        if (ov8 && or8) begin
            if (q8.size() == 0) begin
                check_eq("spur8", {31'b0, ov8}, 32'd0);
            end else begin
                e = q8.pop_front();
                check_eq("res8", {22'b0, of8, co8, s8}, e.res);
                check_eq("lat8", cyc - e.cyc, ST + stl8 - e.stl);
                em8_res.push_back(int'({of8, co8, s8}));
                em8_cyc.push_back(cyc);
            end
        end
        if (v8 && r8) q8.push_back('{ref_res(8, a8, b8, c8, sb8), cyc, stl8});
        if (ov8 && !or8) stl8++;

        check_eq("rdy6", {31'b0, r6}, {31'b0, (!ov6 || or6)});
        if (ov6 && or6) begin
            if (q6.size() == 0) begin
                check_eq("spur6", {31'b0, ov6}, 32'd0);
            end else begin
                e = q6.pop_front();
                check_eq("res6", {24'b0, of6, co6, s6}, e.res);
                check_eq("lat6", cyc - e.cyc, ST + stl6 - e.stl);
            end
        end
        if (v6 && r6) begin
            q6.push_back('{ref_res(6, a6, b6, c6, sb6), cyc, stl6});
            acc6++;
        end
        if (ov6 && !or6) stl6++;

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v8 = 1'b0; or8 = 1'b1;
        v6 = 1'b0; or6 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_out8", {21'b0, ov8, of8, co8, s8}, 32'd0);
        check_eq("rst_out6", {23'b0, ov6, of6, co6, s6}, 32'd0);
        rst_n = 1'b1;
        q8.delete();
        q6.delete();
        cyc++;
        #1;
        check_eq("rst_rdy8", {31'b0, r8}, 32'd1);
        check_eq("rst_rdy6", {31'b0, r6}, 32'd1);
    endtask

    initial begin
        logic [31:0] snap;
        int guard;

        set8(1'b0, 0, 0, 0, 0, 1'b1);
        set6(1'b0, 0, 0, 0, 0, 1'b1);
        do_reset();

        // Directed add/sub corner cases, one beat at a time.
        for (int i = 0; i < 4; i++) begin
            em8_res.delete();
            em8_cyc.delete();
            set8(1'b1, ta[i], tb[i], 0, ts[i], 1'b1);
            tick();
            set8(1'b0, 0, 0, 0, 0, 1'b1);
            tick();
            tick();
            check_eq("dir_cnt", em8_res.size(), 1);
            if (em8_res.size() > 0) check_eq($sformatf("dir%0d", i), em8_res[0], te[i]);
        end

        // Four back-to-back beats: results on consecutive cycles, in order.
        em8_res.delete();
        em8_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            set8(1'b1, ba[i], bb[i], 0, 0, 1'b1);
            tick();
        end
        set8(1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("b2b_cnt", em8_res.size(), 4);
        if (em8_res.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq($sformatf("b2b%0d", i), em8_res[i], be[i]);
            for (int i = 1; i < 4; i++) check_eq("b2b_gap", em8_cyc[i] - em8_cyc[i-1], 1);
        end

        // Fill the pipe, then hold out_ready low for three cycles.
        set8(1'b1, 8'h11, 8'h22, 0, 0, 1'b1);
        tick();
        set8(1'b1, 8'h33, 8'h44, 1, 0, 1'b1);
        tick();
        snap = {22'b0, ov8, of8, co8, s8};
        check_eq("stall_full", {31'b0, ov8}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            set8(1'b1, $urandom_range(255), $urandom_range(255), 0, 0, 1'b0);
            #1;
            check_eq("stall_rdy", {31'b0, r8}, 32'd0);
            check_eq("stall_hold", {22'b0, ov8, of8, co8, s8}, snap);
            tick();
        end
        set8(1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("stall_drain", q8.size(), 0);

        // Reset with two beats in flight: nothing may surface afterwards.
        set8(1'b1, 8'h01, 8'h01, 0, 0, 1'b1);
        tick();
        set8(1'b1, 8'h02, 8'h02, 0, 1, 1'b1);
        tick();
        do_reset();
        set8(1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with random stalls on both instances.
        guard = 0;
        while (acc6 < 10000 && guard < 60000) begin
            set8(($urandom_range(3) != 0), $urandom_range(255), $urandom_range(255),
                 $urandom_range(1), $urandom_range(1), ($urandom_range(3) != 0));
            set6(($urandom_range(3) != 0), $urandom_range(63), $urandom_range(63),
                 $urandom_range(1), $urandom_range(1), ($urandom_range(3) != 0));
            tick();
            guard++;
        end
        check_eq("rand_beats", acc6 >= 10000, 1);
        set8(1'b0, 0, 0, 0, 0, 1'b1);
        set6(1'b0, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("drain8", q8.size(), 0);
        check_eq("drain6", q6.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
